// File: rtl/bcd_timer_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_timer_ctrl
//   Sequencing controller for an external 2-digit BCD (00-99) counter.
//   Turns start/stop/clear commands into clear/enable strobes for the
//   counter, paces counting with a clock prescaler and stops when the
//   counter reaches a latched BCD target, pulsing done.
//
//   Optional feature macro: AUTO_RELOAD_EN
//     defined   : a target match reloads (LOAD) and counting restarts from
//                 00, giving a periodic timer; DONE is never entered.
//     undefined : one-shot; a match parks the FSM in DONE.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   start (IDLE/DONE) or resume (PAUSE)
//   stop       in   pause counting (only acts in RUN)
//   clear      in   abort to IDLE and clear counter, any state
//   tgt_tens   in   [3:0] target tens digit, latched on accepted start
//   tgt_units  in   [3:0] target units digit, latched on accepted start
//   cnt_tens   in   [3:0] counter tens digit
//   cnt_units  in   [3:0] counter units digit
//   cnt_clr    out  counter synchronous clear strobe (combinational)
//   cnt_en     out  counter increment strobe (combinational)
//   busy       out  state is LOAD or RUN
//   done       out  registered one-cycle pulse on target reached
//   err        out  registered sticky flag: start refused, non-BCD target
//   state      out  [2:0] IDLE=0 LOAD=1 RUN=2 PAUSE=3 DONE=4
//
// Command handshake: commands are level inputs sampled every rising edge;
// there is no ready/valid back-pressure. Priority is clear > stop > start.
// stop has an effect only in RUN, so it never masks a start elsewhere.
// ---------------------------------------------------------------------------
module bcd_timer_ctrl #(
    parameter int unsigned PRESCALE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [3:0] tgt_tens,
    input  logic [3:0] tgt_units,
    input  logic [3:0] cnt_tens,
    input  logic [3:0] cnt_units,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    state_t      cur_q, nxt;
    logic [15:0] pre_q, pre_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        clr_c, en_c;
    logic        match;
    logic        tgt_ok;

    assign match  = ({cnt_tens, cnt_units} == tgt_q);
    assign tgt_ok = (tgt_tens <= 4'd9) && (tgt_units <= 4'd9);

    always_comb begin
        nxt    = cur_q;
        pre_d  = pre_q;
        tgt_d  = tgt_q;
        done_d = 1'b0;
        err_d  = err_q;
        clr_c  = 1'b0;
        en_c   = 1'b0;

        if (clear) begin
            nxt   = S_IDLE;
            clr_c = 1'b1;
            pre_d = 16'd0;
            err_d = 1'b0;
        end else begin
            case (cur_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (!tgt_ok) begin
                            err_d = 1'b1;
                        end else begin
                            tgt_d = {tgt_tens, tgt_units};
                            err_d = 1'b0;
                            nxt   = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    clr_c = 1'b1;
                    pre_d = 16'd0;
                    nxt   = S_RUN;
                end
                S_RUN: begin
                    if (stop) begin
                        nxt = S_PAUSE;
                    end else if (match) begin
`ifdef AUTO_RELOAD_EN
                        nxt    = S_LOAD;
`else
                        nxt    = S_DONE;
`endif
                        done_d = 1'b1;
                    end else if (pre_q == PRE_MAX) begin
                        // Tick: wrap the prescaler and bump the counter.
                        pre_d = 16'd0;
                        en_c  = 1'b1;
                    end else begin
                        pre_d = pre_q + 16'd1;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        nxt = S_RUN;
                    end
                end
                default: begin
                    nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q  <= S_IDLE;
            pre_q  <= 16'd0;
            tgt_q  <= 8'h00;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cur_q  <= nxt;
            pre_q  <= pre_d;
            tgt_q  <= tgt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Strobes are suppressed while reset is asserted so the counter is
    // never disturbed by commands arriving during reset.
    assign cnt_clr = clr_c & ~rst;
    assign cnt_en  = en_c & ~rst;
    assign busy    = (cur_q == S_LOAD) || (cur_q == S_RUN);
    assign done    = done_q;
    assign err     = err_q;
    assign state   = cur_q;

endmodule
